// File: rtl/net_pkg.sv
// net_pkg: shared constants for the 64b/66b-style transmit framer.
//   - SYNC_DATA / SYNC_CTRL sync-header values
//   - block type bytes (start, idle, terminate T0..T7)
//   - full start / idle / T0 block images
//   - framer state encoding
package net_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam logic [7:0] TYPE_START = 8'h78;
    localparam logic [7:0] TYPE_IDLE  = 8'h1E;
    localparam logic [7:0] TYPE_T0    = 8'h87;
    localparam logic [7:0] TYPE_T1    = 8'h99;
    localparam logic [7:0] TYPE_T2    = 8'hAA;
    localparam logic [7:0] TYPE_T3    = 8'hB4;
    localparam logic [7:0] TYPE_T4    = 8'hCC;
    localparam logic [7:0] TYPE_T5    = 8'hD2;
    localparam logic [7:0] TYPE_T6    = 8'hE1;
    localparam logic [7:0] TYPE_T7    = 8'hFF;

    // Preamble/SFD image with the start type in the low byte.
    localparam logic [63:0] START_BLOCK = 64'hD555_5555_5555_5578;
    localparam logic [63:0] IDLE_BLOCK  = 64'h0000_0000_0000_001E;
    localparam logic [63:0] T0_BLOCK    = 64'h0000_0000_0000_0087;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TERM = 2'd2,
        ST_IPG  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/net_tx_term_enc.sv
// net_tx_term_enc: combinational terminate encoder.
// Ports:
//   in_bytes   in   4  valid-byte count of the last word
//   full_word  out  1  word carries 8 bytes (counts 0 and 8..15 treated as 8)
//   term_type  out  8  terminate type byte T_k for k = 1..7 (T0 otherwise)
//   byte_mask  out  8  bit i set when payload byte i is kept in the terminate block
module net_tx_term_enc
    import net_pkg::*;
(
    input  logic [3:0] in_bytes,
    output logic       full_word,
    output logic [7:0] term_type,
    output logic [7:0] byte_mask
);

    always_comb begin
        full_word = 1'b1;
        term_type = TYPE_T0;
        byte_mask = 8'hFF;
        case (in_bytes)
            4'd1: begin full_word = 1'b0; term_type = TYPE_T1; byte_mask = 8'h01; end
            4'd2: begin full_word = 1'b0; term_type = TYPE_T2; byte_mask = 8'h03; end
            4'd3: begin full_word = 1'b0; term_type = TYPE_T3; byte_mask = 8'h07; end
            4'd4: begin full_word = 1'b0; term_type = TYPE_T4; byte_mask = 8'h0F; end
            4'd5: begin full_word = 1'b0; term_type = TYPE_T5; byte_mask = 8'h1F; end
            4'd6: begin full_word = 1'b0; term_type = TYPE_T6; byte_mask = 8'h3F; end
            4'd7: begin full_word = 1'b0; term_type = TYPE_T7; byte_mask = 8'h7F; end
            default: ;
        endcase
    end

endmodule

// File: rtl/net_tx_framer.sv
// net_tx_framer: wraps payload words into start / data / terminate blocks
// behind a one-entry output register with backpressure (full).
// Optional feature macro: NET_TX_IDLE_FILL_EN -- emit idle blocks (64'h1E)
// in IDLE without a pending start and in every IPG slot; when undefined,
// IDLE/IPG emit nothing and IPG counts clock cycles.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_data/in_valid/in_last   payload word stream
//   in_bytes                   valid bytes in the last word
//   in_ready                   word accepted this cycle
//   full                       downstream cannot take a block
//   data_outd/data_outc/write  output block, sync header, block valid
//   busy                       frame in progress
//   frame_cnt                  terminate blocks issued (wraps)
module net_tx_framer
    import net_pkg::*;
#(
    parameter int DWIDTH     = 64,
    parameter int CWIDTH     = 2,
    parameter int IPG_BLOCKS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [3:0]        in_bytes,
    output logic              in_ready,
    input  logic              full,
    output logic [DWIDTH-1:0] data_outd,
    output logic [CWIDTH-1:0] data_outc,
    output logic              write,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam logic [3:0] IPG_LAST = 4'(IPG_BLOCKS - 1);

    tx_state_t         state, state_nxt;
    logic [3:0]        ipg_cnt, ipg_cnt_nxt;
    logic [15:0]       frame_cnt_nxt;

    logic              slot;
    logic              accept;
    logic              blk_vld;
    logic [DWIDTH-1:0] blk_d;
    logic [CWIDTH-1:0] blk_c;

    logic              full_word;
    logic [7:0]        term_type;
    logic [7:0]        byte_mask;
    logic [DWIDTH-1:0] keep_mask;
    logic [DWIDTH-1:0] term_blk;

    net_tx_term_enc u_term_enc (
        .in_bytes  (in_bytes),
        .full_word (full_word),
        .term_type (term_type),
        .byte_mask (byte_mask)
    );

    // A slot is any edge where the output register may take a new block.
    assign slot     = !write || !full;
    assign in_ready = (state == ST_DATA) && slot;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_DATA) || (state == ST_TERM) ||
                      ((state == ST_IDLE) && slot && in_valid);

    // Terminate block: kept payload bytes move up one byte to make room
    // for the type byte in [7:0].
    always_comb begin
        keep_mask = '0;
        for (int i = 0; i < 8; i++) begin
            if (8 * i + 8 <= DWIDTH) keep_mask[8*i +: 8] = {8{byte_mask[i]}};
        end
        term_blk = ((in_data & keep_mask) << 8) | DWIDTH'(term_type);
    end

    always_comb begin
        state_nxt     = state;
        ipg_cnt_nxt   = ipg_cnt;
        frame_cnt_nxt = frame_cnt;
        blk_vld       = 1'b0;
        blk_d         = '0;
        blk_c         = '0;
        case (state)
            ST_IDLE: begin
                if (slot) begin
                    if (in_valid) begin
                        blk_vld   = 1'b1;
                        blk_d     = DWIDTH'(START_BLOCK);
                        blk_c     = CWIDTH'(SYNC_CTRL);
                        state_nxt = ST_DATA;
                    end
`ifdef NET_TX_IDLE_FILL_EN
                    else begin
                        blk_vld = 1'b1;
                        blk_d   = DWIDTH'(IDLE_BLOCK);
                        blk_c   = CWIDTH'(SYNC_CTRL);
                    end
`endif
                end
            end
            ST_DATA: begin
                if (accept) begin
                    blk_vld = 1'b1;
                    if (!in_last || full_word) begin
                        blk_d = in_data;
                        blk_c = CWIDTH'(SYNC_DATA);
                        if (in_last) state_nxt = ST_TERM;
                    end else begin
                        blk_d         = term_blk;
                        blk_c         = CWIDTH'(SYNC_CTRL);
                        frame_cnt_nxt = frame_cnt + 16'd1;
                        ipg_cnt_nxt   = '0;
                        state_nxt     = ST_IPG;
                    end
                end
            end
            ST_TERM: begin
                if (slot) begin
                    blk_vld       = 1'b1;
                    blk_d         = DWIDTH'(T0_BLOCK);
                    blk_c         = CWIDTH'(SYNC_CTRL);
                    frame_cnt_nxt = frame_cnt + 16'd1;
                    ipg_cnt_nxt   = '0;
                    state_nxt     = ST_IPG;
                end
            end
            ST_IPG: begin
`ifdef NET_TX_IDLE_FILL_EN
                if (slot) begin
                    blk_vld = 1'b1;
                    blk_d   = DWIDTH'(IDLE_BLOCK);
                    blk_c   = CWIDTH'(SYNC_CTRL);
                    if (ipg_cnt == IPG_LAST) begin
                        ipg_cnt_nxt = '0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        ipg_cnt_nxt = ipg_cnt + 4'd1;
                    end
                end
`else
                // Without fill the gap is timed in clock cycles.
                if (ipg_cnt == IPG_LAST) begin
                    ipg_cnt_nxt = '0;
                    state_nxt   = ST_IDLE;
                end else begin
                    ipg_cnt_nxt = ipg_cnt + 4'd1;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output register stage: loads only on a slot, holds while full.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ipg_cnt   <= '0;
            frame_cnt <= '0;
            write     <= 1'b0;
            data_outd <= '0;
            data_outc <= '0;
        end else begin
            state     <= state_nxt;
            ipg_cnt   <= ipg_cnt_nxt;
            frame_cnt <= frame_cnt_nxt;
            if (slot) begin
                write <= blk_vld;
                if (blk_vld) begin
                    data_outd <= blk_d;
                    data_outc <= blk_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_net_tx_framer.sv
module tb_net_tx_framer;

    localparam int DW  = 64;
    localparam int CW  = 2;
    localparam int IPG = 3;

    localparam logic [63:0] START_B = 64'hD555_5555_5555_5578;
    localparam logic [63:0] IDLE_B  = 64'h0000_0000_0000_001E;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [3:0]    in_bytes = '0;
    logic          in_ready;
    logic          full = 1'b0;
    logic [DW-1:0] data_outd;
    logic [CW-1:0] data_outc;
    logic          write;
    logic          busy;
    logic [15:0]   frame_cnt;

    net_tx_framer #(.DWIDTH(DW), .CWIDTH(CW), .IPG_BLOCKS(IPG)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .in_ready  (in_ready),
        .full      (full),
        .data_outd (data_outd),
        .data_outc (data_outc),
        .write     (write),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [63:0] d;
        logic [1:0]  c;
        int          kind;   // 0 start, 1 data, 2 terminate
    } blk_t;

    typedef struct {
        logic [63:0] d;
        logic        last;
        logic [3:0]  bytes;
    } word_t;

    blk_t  exp_q[$];
    word_t word_q[$];
    int    terms = 0;
    logic [7:0] ttype [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

    // Build one frame: stimulus words plus the block sequence it must produce.
    task automatic push_frame(input int n, input logic [3:0] lb);
        blk_t        b;
        word_t       w;
        int          eff;
        logic [63:0] m;
        b = '{START_B, 2'b01, 0};
        exp_q.push_back(b);
        for (int i = 0; i < n; i++) begin
            w.d     = {$urandom, $urandom};
            w.last  = (i == n - 1);
            w.bytes = w.last ? lb : 4'($urandom_range(15));
            word_q.push_back(w);
            if (!w.last) begin
                b = '{w.d, 2'b10, 1};
                exp_q.push_back(b);
            end else begin
                eff = (lb == 4'd0 || lb > 4'd8) ? 8 : int'(lb);
                if (eff == 8) begin
                    b = '{w.d, 2'b10, 1};
                    exp_q.push_back(b);
                    b = '{64'h87, 2'b01, 2};
                    exp_q.push_back(b);
                end else begin
                    m = '0;
                    for (int j = 0; j < eff; j++) m[8*j +: 8] = w.d[8*j +: 8];
                    b = '{(m << 8) | {56'd0, ttype[eff]}, 2'b01, 2};
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // full_mode: 0 never full, 1 random with full_pct, 2 full for cycles 4..7.
    task automatic run_stream(input int full_mode, input int full_pct, input int vld_pct, input bit b2b);
        int          cyc;
        int          idle_cnt;
        int          term_cyc;
        bit          seen_term;
        bit          in_frame;
        bit          held;
        bit          done;
        logic [63:0] hd;
        logic [1:0]  hc;
        blk_t        e;
        cyc = 0; idle_cnt = 0; term_cyc = 0;
        seen_term = 0; in_frame = 0; held = 0; done = 0;
        hd = '0; hc = '0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            case (full_mode)
                1:       full = ($urandom_range(99) < full_pct);
                2:       full = (cyc >= 4 && cyc < 8);
                default: full = 1'b0;
            endcase
            if (word_q.size() > 0 && (b2b || $urandom_range(99) < vld_pct)) begin
                in_valid = 1'b1;
                in_data  = word_q[0].d;
                in_last  = word_q[0].last;
                in_bytes = word_q[0].bytes;
            end else begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                in_last  = 1'($urandom_range(1));
                in_bytes = 4'($urandom_range(15));
            end
            #1;
            if (held) begin
                check("hold_write", 64'(write), 64'd1);
                check("hold_d", data_outd, hd);
                check("hold_c", 64'(data_outc), 64'(hc));
            end
            held = write && full;
            hd   = data_outd;
            hc   = data_outc;
            if (write && full) check("ready_when_full", 64'(in_ready), 64'd0);
            if (write && !full) begin
`ifdef NET_TX_IDLE_FILL_EN
                if (data_outc == 2'b01 && data_outd == IDLE_B) begin
                    check("idle_outside_frame", 64'(in_frame), 64'd0);
                    idle_cnt++;
                end else
`endif
                begin
                    if (exp_q.size() == 0) begin
                        check("extra_block", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("blk_d", data_outd, e.d);
                        check("blk_c", 64'(data_outc), 64'(e.c));
                        if (e.kind == 0) begin
                            if (seen_term) begin
`ifdef NET_TX_IDLE_FILL_EN
                                if (b2b) check("ipg_idles", 64'(idle_cnt), 64'(IPG));
                                else     check("ipg_min", 64'(idle_cnt >= IPG), 64'd1);
`else
                                if (b2b) check("ipg_gap", 64'(cyc - term_cyc), 64'(IPG + 1));
`endif
                            end
                            in_frame = 1;
                        end else if (e.kind == 2) begin
                            terms++;
                            check("frame_cnt", 64'(frame_cnt), 64'(terms[15:0]));
                            in_frame  = 0;
                            seen_term = 1;
                            term_cyc  = cyc;
                            idle_cnt  = 0;
                        end
                    end
                end
            end
            if (in_valid && in_ready) void'(word_q.pop_front());
            if (exp_q.size() == 0 && word_q.size() == 0) done = 1;
            cyc++;
        end
        check("run_complete", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        full     = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_write", 64'(write), 64'd0);
        check("rst_data", data_outd, 64'd0);
        check("rst_sync", 64'(data_outc), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset after the second data word of a frame
        acc = 0;
        for (int i = 0; i < 20 && acc < 2; i++) begin
            @(negedge clk);
            full     = 1'b0;
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_bytes = 4'd8;
            in_data  = {$urandom, $urandom};
            #1;
            if (in_valid && in_ready) acc++;
        end
        check("midrst_words_accepted", 64'(acc), 64'd2);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_write", 64'(write), 64'd0);
        check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        terms = 0;

        // Directed frames: 3 words ending with 3 bytes, one full word, in_bytes=0
        push_frame(3, 4'd3);
        push_frame(1, 4'd8);
        push_frame(2, 4'd0);
        run_stream(0, 0, 100, 1'b0);

        // Backpressure held for four cycles in the middle of a frame
        push_frame(6, 4'd5);
        run_stream(2, 0, 100, 1'b0);

        // Back-to-back frames with continuous valid
        for (int f = 0; f < 4; f++) push_frame(1 + $urandom_range(3), 4'($urandom_range(15)));
        run_stream(0, 0, 100, 1'b1);

        // Randomized frames, random valid gaps and backpressure
        for (int f = 0; f < 40; f++) push_frame(1 + $urandom_range(5), 4'($urandom_range(15)));
        run_stream(1, 30, 70, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
